// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read-side drain engine.
package async_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int RD_DEFAULT_COUNT = 25;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/async_fifo_rd_skid.sv
// Two-entry skid buffer: ordered storage with a registered occupancy count.
module async_fifo_rd_skid
  import async_fifo_pkg::*;
#(
  parameter int W = FIFO_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;

  // Caller guarantees push only when occ<2 and pop only when occ!=0.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/async_fifo_rd_drain.sv
// Read-side drain engine: pops cmd_count words from a show-ahead FIFO onto a stream.
// Optional stall counters enabled by ASYNC_FIFO_RD_STATS_EN.
module async_fifo_rd_drain
  import async_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_WIDTH,
  parameter int CNT_W  = 16
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              rempty,
  input  logic [DATA_W-1:0] rdata,
  output logic              rinc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  popped,
`ifdef ASYNC_FIFO_RD_STATS_EN
  output logic [CNT_W-1:0]  stall_empty,
  output logic [CNT_W-1:0]  stall_full,
`endif
  output rd_state_e         dbg_state
);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] popped_q, popped_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       occ;
  logic             xfer;
  logic             take_start;

  // Stream handshake: a word moves when out_valid && out_ready on an rclk edge;
  // out_valid never depends on out_ready, and rinc never depends on out_ready.
  assign rinc = (state_q == RD_RUN) && !rempty && (occ != 2'd2) && (popped_q != target_q);
  assign xfer = out_valid && out_ready;
  assign take_start = start && ((state_q == RD_IDLE) || (state_q == RD_DONE));

  async_fifo_rd_skid #(.W(DATA_W)) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (rinc),
    .push_data (rdata),
    .pop       (xfer),
    .occ       (occ),
    .head      (out_data)
  );

  assign out_valid = (occ != 2'd0);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    popped_d = popped_q;
    if (rinc) begin
      popped_d = popped_q + CNT_W'(1);
    end
    case (state_q)
      RD_IDLE, RD_DONE: begin
        if (start) begin
          target_d = cmd_count;
          popped_d = '0;
          state_d  = (cmd_count == '0) ? RD_DONE : RD_RUN;
        end
      end
      RD_RUN: begin
        if (rinc && (popped_q + CNT_W'(1) == target_q)) begin
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (occ == 2'd0) begin
          state_d = RD_DONE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
    busy_d = (state_d == RD_RUN) || (state_d == RD_DRAIN);
    done_d = (state_d == RD_DONE);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q  <= RD_IDLE;
      target_q <= '0;
      popped_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      popped_q <= popped_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign popped    = popped_q;
  assign dbg_state = state_q;

`ifdef ASYNC_FIFO_RD_STATS_EN
  logic [CNT_W-1:0] stall_empty_q, stall_empty_d;
  logic [CNT_W-1:0] stall_full_q, stall_full_d;

  always_comb begin
    stall_empty_d = stall_empty_q;
    stall_full_d  = stall_full_q;
    if (take_start) begin
      stall_empty_d = '0;
      stall_full_d  = '0;
    end else if (state_q == RD_RUN) begin
      if (rempty && (popped_q != target_q) && (stall_empty_q != '1)) begin
        stall_empty_d = stall_empty_q + CNT_W'(1);
      end
      if (!rempty && (occ == 2'd2) && (stall_full_q != '1)) begin
        stall_full_d = stall_full_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stall_empty_q <= '0;
      stall_full_q  <= '0;
    end else begin
      stall_empty_q <= stall_empty_d;
      stall_full_q  <= stall_full_d;
    end
  end

  assign stall_empty = stall_empty_q;
  assign stall_full  = stall_full_q;
`else
  logic unused_take_start;
  assign unused_take_start = take_start;
`endif

endmodule
